// File: rtl/array_17_ctrl.sv
// array_17_ctrl: request arbiter and read-response buffer in front of a
// single-port RW0 array (one access per cycle, one-cycle read latency).
// Optional feature macro: ARRAY_17_CTRL_INIT_EN zero-fills the array after reset.
module array_17_ctrl #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 50
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              init_done,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef ARRAY_17_CTRL_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic              init_run_q;
  logic              init_done_q;
  logic [ADDR_W-1:0] init_cnt_q;
  logic              init_busy_c;

  logic [DATA_W-1:0] fifo_q [2];
  logic              fifo_wr_ptr_q;
  logic              fifo_rd_ptr_q;
  logic [1:0]        fifo_cnt_q;
  logic              inflight_q;
  logic              rr_wr_first_q;

  logic [1:0]        credit_c;
  logic              pop_c;
  logic              rd_elig_c;
  logic              rd_go_c;
  logic              wr_go_c;
  logic              conflict_c;

  assign init_busy_c = INIT_EN & init_run_q & ~init_done_q;
  assign init_done   = init_done_q;

  assign rsp_valid = (fifo_cnt_q != 2'd0);
  assign rsp_data  = fifo_q[fifo_rd_ptr_q];
  assign pop_c     = rsp_valid & rsp_ready;

  // Reads reserve a FIFO slot at issue; a same-cycle pop frees one.
  assign credit_c   = fifo_cnt_q + 2'(inflight_q);
  assign rd_elig_c  = init_done_q & ((credit_c < 2'd2) | ((credit_c == 2'd2) & pop_c));
  assign rd_ready   = rd_elig_c & (~wr_valid | ~rr_wr_first_q);
  assign wr_ready   = init_done_q & (~(rd_valid & rd_elig_c) | rr_wr_first_q);
  assign rd_go_c    = rd_valid & rd_ready;
  assign wr_go_c    = wr_valid & wr_ready;
  assign conflict_c = rd_valid & wr_valid & rd_elig_c;

  // Array port mux: init fill, then the granted write or read.
  always_comb begin
    mem_en    = 1'b0;
    mem_wmode = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (init_busy_c) begin
      mem_en    = 1'b1;
      mem_wmode = 1'b1;
      mem_addr  = init_cnt_q;
    end else if (wr_go_c) begin
      mem_en    = 1'b1;
      mem_wmode = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end else if (rd_go_c) begin
      mem_en    = 1'b1;
      mem_addr  = rd_addr;
    end
  end

  // Init sequencer: zero-fill walk when enabled, otherwise ready after one edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      init_run_q  <= 1'b0;
      init_done_q <= 1'b0;
      init_cnt_q  <= '0;
    end else begin
      init_run_q <= 1'b1;
      if (init_busy_c) begin
        init_cnt_q <= init_cnt_q + ADDR_W'(1);
      end
      if (!INIT_EN || (init_busy_c && (init_cnt_q == LAST_ADDR))) begin
        init_done_q <= 1'b1;
      end
    end
  end

  // In-flight read, response FIFO pointers/occupancy and round-robin pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q    <= 1'b0;
      fifo_wr_ptr_q <= 1'b0;
      fifo_rd_ptr_q <= 1'b0;
      fifo_cnt_q    <= 2'd0;
      rr_wr_first_q <= 1'b0;
    end else begin
      inflight_q <= rd_go_c;
      if (inflight_q) begin
        fifo_wr_ptr_q <= ~fifo_wr_ptr_q;
      end
      if (pop_c) begin
        fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
      end
      fifo_cnt_q <= fifo_cnt_q + 2'(inflight_q) - 2'(pop_c);
      if (conflict_c) begin
        rr_wr_first_q <= ~rr_wr_first_q;
      end
    end
  end

  // Capture array read data one cycle after the read was issued.
  always_ff @(posedge clock) begin
    if (inflight_q) begin
      fifo_q[fifo_wr_ptr_q] <= mem_rdata;
    end
  end

endmodule
